// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA timing blocks.
package vga_pkg;

   // Recovery FSM: hunt for a frame boundary, measure one frame, then track.
   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2
   } vga_state_e;

   // Default width of position counters and measured sizes.
   localparam int W_DEFAULT = 10;

   // Standard 640x480 timing as produced by the synchronizer.
   localparam int LINE_CLKS   = 793;
   localparam int HSYNC_CLKS  = 95;
   localparam int VSYNC_LINES = 2;
   localparam int FRAME_LINES = 480;

   // Level of an inactive (active-low) sync line.
   localparam logic SYNC_IDLE = 1'b1;

endpackage

// File: rtl/sync_edge_detect.sv
// One-register edge detector for an active-low sync input.
// Edges are combinational on the live input so they act on the clock edge
// that samples them.
module sync_edge_detect
   import vga_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise,
   output logic fall
);

   logic q;

   // Previous sample of the sync line; idles high so reset never fakes an edge.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
      if (!rst) q <= SYNC_IDLE;
      else      q <= d;
   end

   // Edges are masked while reset is held so no pulse escapes during reset.
   assign fall = rst & q & ~d;
   assign rise = rst & ~q & d;

endmodule

// File: rtl/vga_timing_recovery.sv
// Recovers col/row position from an hsync/vsync pair, measures line length,
// frame length and hsync width, and declares lock after a consistent frame.
module vga_timing_recovery
   import vga_pkg::*;
#(
   parameter int W        = W_DEFAULT,
   parameter int MIN_LINE = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         hsync,
   input  logic         vsync,
   output logic [W-1:0] col,
   output logic [W-1:0] row,
   output logic [W-1:0] line_size,
   output logic [W-1:0] frame_size,
   output logic [W-1:0] hsync_width,
   output logic         locked,
   output logic         frame_start,
   output logic         err
);

   localparam logic [W-1:0] CNT_MAX = '1;
   localparam logic [W-1:0] CNT_PRE = CNT_MAX - W'(1);
   localparam logic [W-1:0] MIN_LEN = W'(MIN_LINE);

   logic         hs_fall, hs_rise, vs_fall, vs_rise_unused;
   logic [W-1:0] line_len, row_len, hs_cnt;
   logic [W-1:0] ref_line, ref_frame;
   logic         col_ovf, col_valid, consistent;
   logic         col_sat_evt, row_sat_evt, short_line, line_bad;
   logic         lock_lost, measure_ok;
   vga_state_e   state, next_state;

   sync_edge_detect u_hs_edge (
      .clk  (clk),
      .rst  (rst),
      .d    (hsync),
      .rise (hs_rise),
      .fall (hs_fall)
   );

   // The vsync rising edge carries no timing information here.
   sync_edge_detect u_vs_edge (
      .clk  (clk),
      .rst  (rst),
      .d    (vsync),
      .rise (vs_rise_unused),
      .fall (vs_fall)
   );

   // Length of the line/frame that would end now, saturating at all-ones.
   assign line_len = (col == CNT_MAX) ? CNT_MAX : col + W'(1);
   assign row_len  = (row == CNT_MAX) ? CNT_MAX : row + W'(1);

   // Counters about to hit saturation on this clock.
   assign col_sat_evt = ~hs_fall & (col == CNT_PRE);
   assign row_sat_evt = hs_fall & ~vs_fall & (row == CNT_PRE);

   // A short line only counts once a real line start has been seen since reset.
   assign short_line = hs_fall & col_valid & (line_len < MIN_LEN);
   assign line_bad   = short_line |
                       (hs_fall & (ref_line != '0) & (line_len != ref_line));

   // Lock is lost on any geometry change or counter saturation.
   assign lock_lost = (hs_fall & (line_len != ref_line)) |
                      (vs_fall & (row_len != ref_frame)) |
                      col_sat_evt | row_sat_evt;

   // The line closing on this vs_fall is folded into the frame verdict.
   assign measure_ok = consistent & ~line_bad & ~col_ovf;

   // Column counter, line length and overflow tracking.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col       <= '0;
         line_size <= '0;
         col_ovf   <= 1'b0;
         col_valid <= 1'b0;
      end else if (hs_fall) begin
         col       <= '0;
         line_size <= line_len;
         col_ovf   <= 1'b0;
         col_valid <= 1'b1;
      end else begin
         col <= line_len;
         if (col_sat_evt) col_ovf <= 1'b1;
      end
   end

   // Hsync low-time counter, published on the rising edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hs_cnt      <= '0;
         hsync_width <= '0;
      end else begin
         if (hs_fall)                        hs_cnt <= W'(1);
         else if (!hsync && hs_cnt != CNT_MAX) hs_cnt <= hs_cnt + W'(1);
         if (hs_rise) hsync_width <= hs_cnt;
      end
   end

   // Row counter and frame length; vs_fall wins over a coincident hs_fall.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row        <= '0;
         frame_size <= '0;
      end else if (vs_fall) begin
         row        <= '0;
         frame_size <= row_len;
      end else if (hs_fall) begin
         row <= row_len;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= SEARCH;
      else      state <= next_state;
   end

   // FSM next-state logic.
   always_comb begin
      // NOTE: default assignment first so no path leaves next_state unassigned (no latch).
      next_state = state;
      case (state)
         SEARCH:  if (vs_fall)               next_state = MEASURE;
         MEASURE: if (vs_fall && measure_ok) next_state = LOCKED;
         LOCKED:  if (lock_lost)             next_state = SEARCH;
         default:                            next_state = SEARCH;
      endcase
   end

   // FSM outputs: err and frame_start pulse in the cycle the edge is seen.
   always_comb begin
      locked      = (state == LOCKED);
      frame_start = vs_fall;
      err         = (state == LOCKED) ? lock_lost : short_line;
   end

   // Reference geometry captured while measuring.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ref_line   <= '0;
         ref_frame  <= '0;
         consistent <= 1'b0;
      end else begin
         case (state)
            SEARCH: begin
               if (vs_fall) begin
                  ref_line   <= '0;
                  consistent <= 1'b1;
               end
            end
            MEASURE: begin
               if (vs_fall) begin
                  if (measure_ok) begin
                     ref_frame <= row_len;
                  end else begin
                     ref_line   <= '0;
                     consistent <= 1'b1;
                  end
               end else if (hs_fall) begin
                  if (ref_line == '0) ref_line <= line_len;
                  if (line_bad)       consistent <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_vga_timing_recovery.sv
// Directed bench for vga_timing_recovery: sync waveforms are generated one
// clock at a time and results compared against hand-computed values.
module tb_vga_timing_recovery;
   import vga_pkg::*;

   localparam int W         = 10;
   localparam int STD_LINES = 16;
   localparam int SM_LEN    = 20;
   localparam int SM_HS     = 4;
   localparam int SM_LINES  = 6;
   localparam int SM_VS     = 1;

   logic         clk = 1'b0;
   logic         rst;
   logic         hsync;
   logic         vsync;
   logic [W-1:0] col, row, line_size, frame_size, hsync_width;
   logic         locked, frame_start, err;

   int n_vec    = 0;
   int n_bad    = 0;
   int cyc      = 0;
   int err_cnt  = 0;
   int fs_cnt   = 0;
   int lock_cnt = 0;
   int fs_last  = 0;
   int fs_prev  = 0;
   int col_max  = 0;
   int row_max  = 0;
   int e0       = 0;
   int l0       = 0;

   vga_timing_recovery #(
      .W        (W),
      .MIN_LINE (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .hsync       (hsync),
      .vsync       (vsync),
      .col         (col),
      .row         (row),
      .line_size   (line_size),
      .frame_size  (frame_size),
      .hsync_width (hsync_width),
      .locked      (locked),
      .frame_start (frame_start),
      .err         (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Drive one clock of sync levels, then observe the pre-edge outputs.
   task automatic step(input logic hs, input logic vs);
      @(negedge clk);
      hsync = hs;
      vsync = vs;
      #1;
      if (err) err_cnt++;
      if (locked) lock_cnt++;
      if (frame_start) begin
         fs_cnt++;
         fs_prev = fs_last;
         fs_last = cyc;
      end
      if (int'(col) > col_max) col_max = int'(col);
      if (int'(row) > row_max) row_max = int'(row);
      cyc++;
   endtask

   // Let the clock edge act on the last driven step.
   task automatic settle();
      @(posedge clk);
      #1;
   endtask

   // One frame with vsync and hsync falling together at its first clock.
   task automatic drive_frame(input int len, input int hs_w, input int lines,
                              input int vs_lines, input bit skip_first);
      for (int l = 0; l < lines; l++)
         for (int c = 0; c < len; c++)
            if (!(skip_first && l == 0 && c == 0))
               step(c >= hs_w, l >= vs_lines);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst   = 1'b0;
      hsync = 1'b1;
      vsync = 1'b1;

      // Reset with random sync activity
      for (int i = 0; i < 2; i++) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         check("reset_outputs",
               {col, row, line_size, frame_size, hsync_width, locked, frame_start, err}, 64'd0);
      end
      @(negedge clk);
      hsync = 1'b1;
      vsync = 1'b1;
      rst   = 1'b1;
      err_cnt = 0;
      fs_cnt  = 0;
      repeat (20) step(1'b1, 1'b1);
      check("idle_no_edges", err_cnt + fs_cnt, 0);
      check("idle_locked", locked, 0);

      // Standard line timing
      err_cnt = 0;
      fs_cnt  = 0;
      drive_frame(LINE_CLKS, HSYNC_CLKS, STD_LINES, VSYNC_LINES, 1'b0);
      settle();
      check("std_prelock", locked, 0);
      check("std_line_size", line_size, LINE_CLKS);
      check("std_hsync_width", hsync_width, HSYNC_CLKS);
      step(1'b0, 1'b0);
      settle();
      check("std_locked", locked, 1);
      check("std_frame_size", frame_size, STD_LINES);
      check("std_row_start", row, 0);
      check("std_col_start", col, 0);
      col_max = 0;
      row_max = 0;
      drive_frame(LINE_CLKS, HSYNC_CLKS, STD_LINES, VSYNC_LINES, 1'b1);
      check("std_col_max", col_max, LINE_CLKS - 1);
      check("std_row_max", row_max, STD_LINES - 1);
      step(1'b0, 1'b0);
      settle();
      check("std_still_locked", locked, 1);
      check("std_frame_starts", fs_cnt, 3);
      check("std_err_count", err_cnt, 0);

      // Asynchronous reset in the middle of a line
      for (int c = 1; c <= 30; c++) step(1'b0, 1'b0);
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("async_reset_outputs",
            {col, row, line_size, frame_size, hsync_width, locked, frame_start, err}, 64'd0);
      @(negedge clk);
      hsync = 1'b1;
      vsync = 1'b1;
      @(negedge clk);
      rst = 1'b1;

      // Small timing: 20-clock lines, 4-clock hsync, 6-line frames
      err_cnt = 0;
      fs_cnt  = 0;
      repeat (20) step(1'b1, 1'b1);
      drive_frame(SM_LEN, SM_HS, SM_LINES, SM_VS, 1'b0);
      settle();
      check("sm_prelock", locked, 0);
      step(1'b0, 1'b0);
      settle();
      check("sm_lock_2nd_vs", locked, 1);
      drive_frame(SM_LEN, SM_HS, SM_LINES, SM_VS, 1'b1);
      drive_frame(SM_LEN, SM_HS, SM_LINES, SM_VS, 1'b0);
      drive_frame(SM_LEN, SM_HS, SM_LINES, SM_VS, 1'b0);
      step(1'b0, 1'b0);
      settle();
      check("sm_locked", locked, 1);
      check("sm_line_size", line_size, SM_LEN);
      check("sm_hsync_width", hsync_width, SM_HS);
      check("same_clock_frame_size", frame_size, SM_LINES);
      check("same_clock_row", row, 0);
      check("sm_frame_starts", fs_cnt, 5);
      check("sm_frame_period", fs_last - fs_prev, SM_LEN * SM_LINES);
      check("sm_err_count", err_cnt, 0);

      // One 19-clock line while locked
      for (int c = 1; c < SM_LEN; c++) step(c >= SM_HS, 1'b0);
      for (int c = 0; c < SM_LEN - 1; c++) step(c >= SM_HS, 1'b1);
      step(1'b0, 1'b1);
      check("glitch_err", err, 1);
      check("glitch_locked_same_cycle", locked, 1);
      settle();
      check("glitch_locked_dropped", locked, 0);
      for (int c = 1; c < SM_LEN; c++) step(c >= SM_HS, 1'b1);
      for (int l = 3; l < SM_LINES; l++)
         for (int c = 0; c < SM_LEN; c++) step(c >= SM_HS, 1'b1);
      drive_frame(SM_LEN, SM_HS, SM_LINES, SM_VS, 1'b0);
      settle();
      check("relock_wait", locked, 0);
      step(1'b0, 1'b0);
      settle();
      check("relock", locked, 1);
      check("glitch_err_count", err_cnt, 1);

      // hsync stuck high while locked
      e0 = err_cnt;
      repeat (1100) step(1'b1, 1'b1);
      settle();
      check("sat_col", col, 1023);
      check("sat_single_err", err_cnt - e0, 1);
      check("sat_locked", locked, 0);

      // 10-clock lines are below the legal minimum
      e0 = err_cnt;
      l0 = lock_cnt;
      repeat (3) drive_frame(10, 4, 6, 1, 1'b0);
      step(1'b0, 1'b0);
      settle();
      check("short_err_count", err_cnt - e0, 18);
      check("short_never_locked", lock_cnt - l0, 0);
      check("short_line_size", line_size, 10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/vga_timing_recovery.md
Name: vga_timing_recovery

Overview:
- Sink-side counterpart of the VGA synchronizer.
- Observes the hsync/vsync pair on the same clock and recovers col/row position.
- Measures line length, frame length and hsync pulse width, and declares lock once two consecutive frames are consistent.
- Used for loopback checking of the synchronizer and for driving pixel capture logic.

Parameters:
W, 10, width of col/row counters and measured sizes
MIN_LINE, 16, minimum legal line length in clocks; shorter lines are errors

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low
hsync  input  1  horizontal sync, active-low pulse
vsync  input  1  vertical sync, active-low pulse
col  output  W  clocks since last hsync falling edge
row  output  W  hsync falling edges since last vsync falling edge
line_size  output  W  last measured line length in clocks
frame_size  output  W  last measured frame length in lines
hsync_width  output  W  last measured hsync low time in clocks
locked  output  1  timing stable for two consecutive frames
frame_start  output  1  one-cycle pulse on vsync falling edge
err  output  1  one-cycle pulse on loss of lock or illegal timing

Behaviour:
- Reset (rst low, async): all outputs 0; hs_q/vs_q = 1; FSM = SEARCH.
- Edge detect: hs_q/vs_q register hsync/vsync. hs_fall = hs_q & ~hsync; hs_rise = ~hs_q & hsync; same scheme for vs_fall. Edges act on the same clock edge that samples them.
- col:
  - hs_fall: col <= 0, line_size <= col+1.
  - Otherwise col <= col+1, saturating at 2^W-1. Reaching saturation sets an overflow flag, cleared on hs_fall.
- hsync_width: count runs while hsync is low (reset to 1 on hs_fall); on hs_rise, hsync_width <= count.
- row:
  - hs_fall: row <= row+1, saturating.
  - vs_fall: row <= 0, frame_size <= row+1, frame_start = 1 for one cycle.
  - Simultaneous vs_fall and hs_fall: row <= 0, and frame_size counts the current hsync, i.e. frame_size <= row+1.
- FSM:
  - SEARCH: on vs_fall -> MEASURE, with ref_line <= 0 and consistent <= 1.
  - MEASURE:
    - On each hs_fall with ref_line = 0: ref_line <= col+1.
    - On each hs_fall with ref_line != 0: if col+1 != ref_line or col+1 < MIN_LINE, then consistent <= 0.
    - On vs_fall: if consistent and no overflow -> LOCKED, with ref_frame <= row+1. Otherwise stay in MEASURE, restart with ref_line <= 0 and consistent <= 1.
  - LOCKED:
    - locked = 1.
    - Any hs_fall with col+1 != ref_line, any vs_fall with row+1 != ref_frame, or any col/row saturation: err pulses for 1 cycle, locked <= 0 next cycle, FSM -> SEARCH.
- err also pulses in SEARCH/MEASURE when a line shorter than MIN_LINE is seen.
- Measured outputs keep updating regardless of lock state.
- rst asserted mid-frame: immediate clear. After release, no lock before one full frame in MEASURE, i.e. two vs_fall edges.
- hsync/vsync stuck high: counters saturate, no pulses. Saturation in LOCKED gives a single err pulse, then SEARCH.

Decomposition:
- Shared package vga_pkg:
  - FSM state enum (SEARCH, MEASURE, LOCKED).
  - W default.
  - Standard 640x480 constants: LINE_CLKS=793, HSYNC_CLKS=95, VSYNC_LINES=2, FRAME_LINES=480, matching synchronizer bench settings.
- One sub-module, sync_edge_detect: one register plus rise/fall outputs, instantiated twice for hsync and vsync.

Test Plan:
- Reset: hold rst low 2 cycles with random sync inputs -> all outputs 0, locked = 0; release, hsync = vsync = 1 -> no edge pulses.
- Standard timing:
  - Stimulus: drive the synchronizer with hsync_pos=95, line_size=793, vsync_pos=2, frame_size=480.
  - After the 2nd vsync falling edge: line_size = 793, hsync_width = 95, frame_size = 480, locked = 1.
  - Thereafter col counts 0..792 and row counts 0..479.
- Small timing for speed: 20-clock lines, 4-clock hsync, 6-line frames -> locked asserts on the 2nd vs_fall; frame_start pulses once per 120 clocks; err never fires.
- Line glitch while LOCKED: one line shortened to 19 clocks -> err pulses on that hs_fall, locked drops the next cycle, relock two frames later.
- Short line: lines of 10 clocks with MIN_LINE=16 -> err pulses on each such hs_fall; locked stays 0.
- Boundary and abort cases:
  - vsync and hsync fall on the same clock -> row = 0 and frame_size = previous row+1.
  - hsync held high in LOCKED -> col saturates at 1023, single err pulse.
  - rst pulsed mid-line -> outputs cleared asynchronously.
